// File: rtl/mips_trace_pkg.sv
// Shared types for the MEM-stage store trace unit.
package mips_trace_pkg;

    localparam int unsigned TRACE_AW = 32;
    localparam int unsigned TRACE_DW = 32;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        WORD = 2'b01,
        HALF = 2'b10,
        BYTE = 2'b11
    } memwrite_e;

    typedef enum logic [1:0] {
        ARMED   = 2'b00,
        CAPTURE = 2'b01,
        DONE    = 2'b10
    } trace_state_e;

    typedef struct packed {
        logic [TRACE_AW-1:0] addr;
        logic [TRACE_DW-1:0] data;
        logic [1:0]          size;
    } trace_entry_t;

    // A memwrite code other than NONE marks a store event.
    function automatic logic is_store(input logic [1:0] mw);
        return memwrite_e'(mw) != NONE;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Circular trace buffer with FWFT head, optional overwrite-oldest when full.
module trace_fifo
    import mips_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter type entry_t = trace_entry_t,
    localparam int unsigned PW = $clog2(DEPTH),
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clear,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_overwrite_en,
    input  entry_t        i_din,
    output entry_t        o_head,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    entry_t        r_mem [DEPTH];

    logic w_do_pop;
    logic w_blocked;
    logic w_ovw;
    logic w_do_push;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign w_do_pop  = i_pop && !o_empty;
    // Full with no same-cycle pop: either discard or recycle the oldest slot.
    assign w_blocked = i_push && o_full && !w_do_pop;
    assign w_ovw     = w_blocked && i_overwrite_en;
    assign w_do_push = i_push && (!w_blocked || i_overwrite_en);
    assign o_head    = o_empty ? entry_t'('0) : r_mem[r_head];

    // Pointer and occupancy update; clear wins over push/pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_pop || w_ovw) r_head <= r_head + PW'(1);
            if (w_do_push)         r_tail <= r_tail + PW'(1);
            if (w_do_push && !w_do_pop && !w_ovw) r_count <= r_count + CW'(1);
            else if (w_do_pop && !w_do_push)      r_count <= r_count - CW'(1);
        end
    end

    // Entry storage; contents after clear/reset are never observed.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_clear) r_mem[r_tail] <= i_din;
    end

endmodule

// File: rtl/mem_write_tracer.sv
// Store-trace capture for the MEM-stage write port: trigger FSM, drop counter, clear.
module mem_write_tracer
    import mips_trace_pkg::*;
#(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned POST_COUNT = 0,
    parameter int unsigned CNTW       = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic [1:0]                   memwrite,
    input  logic [AW-1:0]                addr,
    input  logic [DW-1:0]                wdata,
    input  logic                         mode,
    input  logic                         trig_en,
    input  logic [AW-1:0]                trig_addr,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic [AW-1:0]                rd_addr,
    output logic [DW-1:0]                rd_data,
    output logic [1:0]                   rd_size,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [CNTW-1:0]              dropped,
    output logic                         triggered,
    output logic                         done
);

    localparam int unsigned CW        = $clog2(DEPTH + 1);
    localparam int unsigned PCW       = $clog2(POST_COUNT + 2);
    localparam int unsigned POST_LAST = (POST_COUNT == 0) ? 0 : POST_COUNT - 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [1:0]    size;
    } entry_t;

    trace_state_e   r_state;
    trace_state_e   w_state_nxt;
    logic [PCW-1:0] r_post_cnt;
    logic [CNTW-1:0] r_dropped;
    logic           r_triggered;

    logic           w_store;
    logic           w_match;
    logic           w_push;
    logic           w_pop;
    logic           w_full;
    logic           w_empty;
    logic           w_drop;
    logic           w_accept;
    logic           w_last;
    logic [CW-1:0]  w_count;
    entry_t         w_din;
    entry_t         w_head;

    assign w_store  = is_store(memwrite);
    assign w_match  = ((addr ^ trig_addr) >> 2) == AW'(0);
    assign w_pop    = !w_empty && rd_ready;
    assign w_drop   = w_push && w_full && !w_pop;
    assign w_accept = w_push && !w_drop;
    assign w_last   = (POST_COUNT != 0) && w_accept && (r_post_cnt == PCW'(POST_LAST));
    assign w_din    = '{addr: addr, data: wdata, size: memwrite};

    // State register; clear re-arms.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     r_state <= ARMED;
        else if (clear) r_state <= ARMED;
        else            r_state <= w_state_nxt;
    end

    // Next-state: first accepted capture leaves ARMED, post-trigger limit ends in DONE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARMED:   if (w_push) w_state_nxt = w_last ? DONE : CAPTURE;
            CAPTURE: if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = DONE;
            default: w_state_nxt = ARMED;
        endcase
    end

    // Push request per state; trigger inputs only matter while ARMED.
    always_comb begin
        w_push = 1'b0;
        case (r_state)
            ARMED:   w_push = w_store && (!trig_en || w_match);
            CAPTURE: w_push = w_store;
            default: w_push = 1'b0;
        endcase
    end

    // Post-trigger count, saturating drop counter and trigger flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_post_cnt  <= '0;
            r_dropped   <= '0;
            r_triggered <= 1'b0;
        end else if (clear) begin
            r_post_cnt  <= '0;
            r_dropped   <= '0;
            r_triggered <= 1'b0;
        end else begin
            if ((POST_COUNT != 0) && w_accept) r_post_cnt <= r_post_cnt + PCW'(1);
            if (w_drop && (r_dropped != '1))   r_dropped  <= r_dropped + CNTW'(1);
            if ((r_state == ARMED) && trig_en && w_store && w_match) r_triggered <= 1'b1;
        end
    end

    trace_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk            (clk),
        .reset          (reset),
        .i_clear        (clear),
        .i_push         (w_push),
        .i_pop          (w_pop),
        .i_overwrite_en (mode),
        .i_din          (w_din),
        .o_head         (w_head),
        .o_full         (w_full),
        .o_empty        (w_empty),
        .o_count        (w_count)
    );

    assign rd_valid  = !w_empty;
    assign rd_addr   = w_head.addr;
    assign rd_data   = w_head.data;
    assign rd_size   = w_head.size;
    assign count     = w_count;
    assign dropped   = r_dropped;
    assign triggered = r_triggered;
    assign done      = (r_state == DONE);

endmodule

// File: tb/tb_mem_write_tracer.sv
// Bench for mem_write_tracer: three configurations share stimulus, queue model checks all.
module tb_mem_write_tracer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clear = 1'b0;
    logic [1:0]  memwrite = 2'b00;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        mode = 1'b0;
    logic        trig_en = 1'b0;
    logic [31:0] trig_addr = '0;
    logic        rd_ready = 1'b0;

    logic        v_a, v_b, v_c;
    logic [31:0] a_a, a_b, a_c, d_a, d_b, d_c;
    logic [1:0]  s_a, s_b, s_c;
    logic [4:0]  cnt_a;
    logic [2:0]  cnt_b;
    logic [3:0]  cnt_c;
    logic [15:0] drp_a, drp_b, drp_c;
    logic        trg_a, trg_b, trg_c, dn_a, dn_b, dn_c;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_write_tracer #(.DEPTH(16), .POST_COUNT(0)) dut_a (
        .clk(clk), .reset(reset), .clear(clear), .memwrite(memwrite), .addr(addr),
        .wdata(wdata), .mode(mode), .trig_en(trig_en), .trig_addr(trig_addr),
        .rd_valid(v_a), .rd_ready(rd_ready), .rd_addr(a_a), .rd_data(d_a), .rd_size(s_a),
        .count(cnt_a), .dropped(drp_a), .triggered(trg_a), .done(dn_a));

    mem_write_tracer #(.DEPTH(4), .POST_COUNT(0)) dut_b (
        .clk(clk), .reset(reset), .clear(clear), .memwrite(memwrite), .addr(addr),
        .wdata(wdata), .mode(mode), .trig_en(trig_en), .trig_addr(trig_addr),
        .rd_valid(v_b), .rd_ready(rd_ready), .rd_addr(a_b), .rd_data(d_b), .rd_size(s_b),
        .count(cnt_b), .dropped(drp_b), .triggered(trg_b), .done(dn_b));

    mem_write_tracer #(.DEPTH(8), .POST_COUNT(2)) dut_c (
        .clk(clk), .reset(reset), .clear(clear), .memwrite(memwrite), .addr(addr),
        .wdata(wdata), .mode(mode), .trig_en(trig_en), .trig_addr(trig_addr),
        .rd_valid(v_c), .rd_ready(rd_ready), .rd_addr(a_c), .rd_data(d_c), .rd_size(s_c),
        .count(cnt_c), .dropped(drp_c), .triggered(trg_c), .done(dn_c));

    typedef struct {
        logic        v;
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  s;
        int          cnt;
        int          drop;
        logic        trg;
        logic        dn;
    } obs_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  s;
    } ent_t;

    // Reference model: a queue per configuration plus armed/capturing/finished phase.
    ent_t mq [3][$];
    int   mdepth [3] = '{16, 4, 8};
    int   mpost  [3] = '{0, 0, 2};
    int   mphase [3];
    int   macc   [3];
    int   mdrop  [3];
    logic mtrig  [3];

    function automatic void model_reset(input int k);
        mq[k].delete();
        mphase[k] = 0;
        macc[k]   = 0;
        mdrop[k]  = 0;
        mtrig[k]  = 1'b0;
    endfunction

    function automatic void model_step(input int k);
        bit   take;
        bit   pop;
        ent_t e;
        if (clear) begin
            model_reset(k);
            return;
        end
        pop  = (mq[k].size() > 0) && rd_ready;
        take = 1'b0;
        if (mphase[k] == 0) begin
            if (memwrite != 2'b00 && (!trig_en || addr[31:2] == trig_addr[31:2])) begin
                take = 1'b1;
                if (trig_en) mtrig[k] = 1'b1;
                mphase[k] = 1;
            end
        end else if (mphase[k] == 1) begin
            take = (memwrite != 2'b00);
        end
        if (pop) void'(mq[k].pop_front());
        if (take) begin
            e.a = addr; e.d = wdata; e.s = memwrite;
            if (mq[k].size() < mdepth[k]) begin
                mq[k].push_back(e);
                macc[k]++;
                if (mpost[k] != 0 && macc[k] == mpost[k]) mphase[k] = 2;
            end else begin
                if (mode) begin
                    void'(mq[k].pop_front());
                    mq[k].push_back(e);
                end
                if (mdrop[k] < 65535) mdrop[k]++;
            end
        end
    endfunction

    function automatic obs_t model_obs(input int k);
        obs_t o;
        o.v = mq[k].size() != 0;
        o.a = o.v ? mq[k][0].a : 32'h0;
        o.d = o.v ? mq[k][0].d : 32'h0;
        o.s = o.v ? mq[k][0].s : 2'b00;
        o.cnt  = mq[k].size();
        o.drop = mdrop[k];
        o.trg  = mtrig[k];
        o.dn   = (mphase[k] == 2);
        return o;
    endfunction

    function automatic obs_t get_obs(input int k);
        obs_t o;
        case (k)
            0: begin o.v = v_a; o.a = a_a; o.d = d_a; o.s = s_a; o.cnt = int'(cnt_a);
                     o.drop = int'(drp_a); o.trg = trg_a; o.dn = dn_a; end
            1: begin o.v = v_b; o.a = a_b; o.d = d_b; o.s = s_b; o.cnt = int'(cnt_b);
                     o.drop = int'(drp_b); o.trg = trg_b; o.dn = dn_b; end
            default: begin o.v = v_c; o.a = a_c; o.d = d_c; o.s = s_c; o.cnt = int'(cnt_c);
                     o.drop = int'(drp_c); o.trg = trg_c; o.dn = dn_c; end
        endcase
        return o;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%h expected=%h", nm, $time, act, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        obs_t g, m;
        string nm;
        for (int k = 0; k < 3; k++) begin
            g = get_obs(k);
            m = model_obs(k);
            nm = $sformatf("%s[%0d]", tag, k);
            chk({nm, ".rd_valid"},  32'(g.v),    32'(m.v));
            chk({nm, ".rd_addr"},   g.a,         m.a);
            chk({nm, ".rd_data"},   g.d,         m.d);
            chk({nm, ".rd_size"},   32'(g.s),    32'(m.s));
            chk({nm, ".count"},     32'(g.cnt),  32'(m.cnt));
            chk({nm, ".dropped"},   32'(g.drop), 32'(m.drop));
            chk({nm, ".triggered"}, 32'(g.trg),  32'(m.trg));
            chk({nm, ".done"},      32'(g.dn),   32'(m.dn));
        end
    endtask

    // One clock: model consumes the inputs seen at the edge, outputs sampled 1 unit later.
    task automatic tick(input string tag);
        for (int k = 0; k < 3; k++) model_step(k);
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic drive(input logic [1:0] mw, input logic [31:0] a, input logic [31:0] d,
                         input logic rdy);
        memwrite = mw; addr = a; wdata = d; rd_ready = rdy;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        drive(2'b00, 32'h0, 32'h0, 1'b0);
        tick("clear");
        clear = 1'b0;
    endtask

    typedef struct {
        logic        clr;
        logic        mode;
        logic        st;
        logic [31:0] data;
        logic        rdy;
        int          e_cnt;
        logic [31:0] e_head;
        int          e_drop;
    } vec_t;

    function automatic vec_t mkv(input logic clr, input logic md, input logic st, input int dat,
                                 input logic rdy, input int ec, input int eh, input int ed);
        vec_t v;
        v.clr = clr; v.mode = md; v.st = st; v.data = 32'(dat); v.rdy = rdy;
        v.e_cnt = ec; v.e_head = 32'(eh); v.e_drop = ed;
        return v;
    endfunction

    vec_t tv [20];
    obs_t o;

    initial begin
        // Depth-4 fill/overflow/drain for both full policies, checked against fixed values.
        tv[0]  = mkv(1, 0, 1, 1, 0, 1, 1, 0);
        tv[1]  = mkv(0, 0, 1, 2, 0, 2, 1, 0);
        tv[2]  = mkv(0, 0, 1, 3, 0, 3, 1, 0);
        tv[3]  = mkv(0, 0, 1, 4, 0, 4, 1, 0);
        tv[4]  = mkv(0, 0, 1, 5, 0, 4, 1, 1);
        tv[5]  = mkv(0, 0, 1, 6, 0, 4, 1, 2);
        tv[6]  = mkv(0, 0, 0, 0, 1, 3, 2, 2);
        tv[7]  = mkv(0, 0, 0, 0, 1, 2, 3, 2);
        tv[8]  = mkv(0, 0, 0, 0, 1, 1, 4, 2);
        tv[9]  = mkv(0, 0, 0, 0, 1, 0, 0, 2);
        tv[10] = mkv(1, 1, 1, 1, 0, 1, 1, 0);
        tv[11] = mkv(0, 1, 1, 2, 0, 2, 1, 0);
        tv[12] = mkv(0, 1, 1, 3, 0, 3, 1, 0);
        tv[13] = mkv(0, 1, 1, 4, 0, 4, 1, 0);
        tv[14] = mkv(0, 1, 1, 5, 0, 4, 2, 1);
        tv[15] = mkv(0, 1, 1, 6, 0, 4, 3, 2);
        tv[16] = mkv(0, 1, 0, 0, 1, 3, 4, 2);
        tv[17] = mkv(0, 1, 0, 0, 1, 2, 5, 2);
        tv[18] = mkv(0, 1, 0, 0, 1, 1, 6, 2);
        tv[19] = mkv(0, 1, 0, 0, 1, 0, 0, 2);

        for (int k = 0; k < 3; k++) model_reset(k);

        // Reset state.
        #12;
        compare_all("reset");
        reset = 1'b1;

        // Basic capture, FWFT head, idle cycles, in-order drain (16-deep instance).
        do_clear();
        drive(2'b01, 32'h10, 32'h11111111, 1'b0); tick("st1");
        o = get_obs(0);
        chk("lat.rd_valid", 32'(o.v), 32'd1);
        chk("lat.rd_data",  o.d, 32'h11111111);
        drive(2'b01, 32'h14, 32'h22222222, 1'b0); tick("st2");
        drive(2'b11, 32'h18, 32'h00000033, 1'b0); tick("st3");
        drive(2'b00, 32'h1C, 32'hDEADBEEF, 1'b0); tick("idle1");
        drive(2'b00, 32'h20, 32'hCAFEF00D, 1'b0); tick("idle2");
        o = get_obs(0);
        chk("basic.count", 32'(o.cnt), 32'd3);
        chk("basic.rd_addr", o.a, 32'h10);
        chk("basic.rd_size", 32'(o.s), 32'd1);
        drive(2'b00, 32'h0, 32'h0, 1'b1); tick("pop1");
        o = get_obs(0);
        chk("basic.pop1.data", o.d, 32'h22222222);
        tick("pop2");
        o = get_obs(0);
        chk("basic.pop2.data", o.d, 32'h00000033);
        chk("basic.pop2.size", 32'(o.s), 32'd3);
        tick("pop3");
        o = get_obs(0);
        chk("basic.pop3.count", 32'(o.cnt), 32'd0);
        chk("basic.pop3.valid", 32'(o.v), 32'd0);

        // Table: depth-4 instance, both full policies.
        for (int i = 0; i < 20; i++) begin
            mode = tv[i].mode;
            if (tv[i].clr) do_clear();
            drive(tv[i].st ? 2'b01 : 2'b00, 32'h100 + (tv[i].data << 2), tv[i].data, tv[i].rdy);
            tick($sformatf("tv%0d", i));
            o = get_obs(1);
            chk($sformatf("tv%0d.count", i),   32'(o.cnt),  32'(tv[i].e_cnt));
            chk($sformatf("tv%0d.head", i),    o.d,         tv[i].e_head);
            chk($sformatf("tv%0d.dropped", i), 32'(o.drop), 32'(tv[i].e_drop));
        end

        // Full buffer plus same-cycle pop and store: no drop in either policy, new entry last.
        for (int md = 0; md < 2; md++) begin
            mode = 1'(md);
            do_clear();
            for (int j = 1; j <= 4; j++) begin
                drive(2'b01, 32'h200 + 32'(j * 4), 32'(j), 1'b0); tick("fill");
            end
            drive(2'b01, 32'h300, 32'h9, 1'b1); tick("fullpop");
            o = get_obs(1);
            chk($sformatf("fullpop%0d.count", md),   32'(o.cnt),  32'd4);
            chk($sformatf("fullpop%0d.dropped", md), 32'(o.drop), 32'd0);
            chk($sformatf("fullpop%0d.head", md),    o.d,         32'd2);
            drive(2'b00, 32'h0, 32'h0, 1'b1);
            for (int j = 0; j < 3; j++) tick("drain");
            o = get_obs(1);
            chk($sformatf("fullpop%0d.last", md), o.d, 32'h9);
            tick("drain");
        end
        mode = 1'b0;

        // Address trigger with post-trigger limit of two (8-deep instance).
        trig_en = 1'b1; trig_addr = 32'h56;
        do_clear();
        drive(2'b01, 32'h50, 32'hA, 1'b0); tick("trg50");
        drive(2'b01, 32'h54, 32'h7, 1'b0); tick("trg54");
        drive(2'b01, 32'h58, 32'h8, 1'b0); tick("trg58");
        drive(2'b01, 32'h5C, 32'h9, 1'b0); tick("trg5C");
        trig_en = 1'b0; trig_addr = 32'h0;
        o = get_obs(2);
        chk("trig.count", 32'(o.cnt), 32'd2);
        chk("trig.triggered", 32'(o.trg), 32'd1);
        chk("trig.done", 32'(o.dn), 32'd1);
        chk("trig.dropped", 32'(o.drop), 32'd0);
        chk("trig.head_addr", o.a, 32'h54);
        chk("trig.head_data", o.d, 32'h7);
        drive(2'b00, 32'h0, 32'h0, 1'b1); tick("trgpop");
        o = get_obs(2);
        chk("trig.second_addr", o.a, 32'h58);
        chk("trig.second_data", o.d, 32'h8);
        tick("trgpop2");

        // Asynchronous reset mid-capture, then recapture and clear-vs-store priority.
        do_clear();
        for (int j = 0; j < 3; j++) begin
            drive(2'b01, 32'h400 + 32'(j * 4), 32'(j + 100), 1'b0); tick("pre_rst");
        end
        #2 reset = 1'b0;
        for (int k = 0; k < 3; k++) model_reset(k);
        #1;
        compare_all("async_rst");
        o = get_obs(0);
        chk("rst.count", 32'(o.cnt), 32'd0);
        chk("rst.valid", 32'(o.v), 32'd0);
        #1 reset = 1'b1;
        drive(2'b01, 32'h200, 32'hBEEF, 1'b0); tick("post_rst");
        o = get_obs(0);
        chk("post_rst.addr", o.a, 32'h200);
        chk("post_rst.data", o.d, 32'hBEEF);
        clear = 1'b1;
        drive(2'b01, 32'h204, 32'hF00D, 1'b0); tick("clr_store");
        clear = 1'b0;
        o = get_obs(0);
        chk("clr_store.count", 32'(o.cnt), 32'd0);

        // Randomized traffic against the model, with varying pressure and policies.
        for (int i = 0; i < 3000; i++) begin
            if (i % 150 == 0) mode = 1'($urandom_range(0, 1));
            clear     = ($urandom_range(0, 99) < 2);
            trig_en   = ($urandom_range(0, 3) == 0);
            trig_addr = 32'h40 + 32'($urandom_range(0, 63));
            drive(($urandom_range(0, 9) < 7) ? 2'($urandom_range(1, 3)) : 2'b00,
                  32'h40 + 32'($urandom_range(0, 63)), $urandom,
                  ((i / 100) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
            tick("rand");
        end
        clear = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
